rll_key_sequencer: RTL
======================

// Module: rll_key_sequencer
// PURPOSE
//  Loads the 16-bit logic-locking key for an RLL-locked combinational netlist (keyIn_0_0..keyIn_0_15)
//  from a chunked key source and checks it against an XOR-fold checksum.
//  Drives the key bus and holds the locked block's outputs masked until the key has settled.
//  Sits between the key-storage interface and the locked datapath; one instance per locked block.
// PARAMETERS
//  KEY_WIDTH      16  width of key bus; must be a multiple of CHUNK_W
//  CHUNK_W        4   bits per key-source transfer
//  SETTLE_CYCLES  2   cycles key_out is held stable before out_enable rises (>=1)
//  MAX_FAIL       3   failed loads before lockout (used only with RLL_KEY_LOCKOUT_EN)
// PORTS
//  clk         in   1          single clock, rising edge
//  rst         in   1          synchronous reset, active-high
//  load_start  in   1          pulse: begin (or restart) a key load
//  kin_valid   in   1          key source chunk valid
//  kin_data    in   CHUNK_W    key chunk, or checksum chunk for the final transfer
//  kin_ready   out  1          sequencer accepts a chunk
//  key_out     out  KEY_WIDTH  key bus to locked netlist keyIn[KEY_WIDTH-1:0]
//  out_enable  out  1          1 = locked-block outputs may be used; 0 = mask them
//  busy        out  1          load, check or settle in progress
//  done        out  1          valid key applied (high in ACTIVE)
//  err         out  1          sticky checksum failure; cleared by load_start or rst
//  locked_out  out  1          lockout reached (tied 0 when the feature is absent)
// BEHAVIOUR
//  Reset: state=IDLE; key_out=0, out_enable=0, kin_ready=0, busy=0, done=0, err=0, locked_out=0; shadow key and counters cleared.
//  NCHUNK = KEY_WIDTH/CHUNK_W. Transfer occurs on a clk edge with kin_valid & kin_ready.
//  States: IDLE, LOAD, CHECK, SETTLE, ACTIVE, FAIL (plus LOCKOUT with macro).
//  IDLE:   load_start -> LOAD; clear err; idx=0.
//  LOAD:   kin_ready=1, busy=1.
//    Transfers 0..NCHUNK-1 write shadow[i*CHUNK_W +: CHUNK_W] (LSB chunk first).
//    Transfer NCHUNK captures chk. After that transfer -> CHECK.
//  CHECK:  one cycle, kin_ready=0, busy=1. fold = XOR of all NCHUNK shadow chunks.
//    fold==chk: key_out<=shadow, settle counter=0 -> SETTLE.
//    fold!=chk: key_out<=0, err<=1, fail_cnt++ -> FAIL.
//  SETTLE: busy=1; counts SETTLE_CYCLES cycles -> ACTIVE.
//  ACTIVE: out_enable=1, done=1, busy=0.
//  FAIL:   one cycle, out_enable=0 -> IDLE; err stays 1.
//  Latency: with no stalls, out_enable/done rise SETTLE_CYCLES+2 edges after the checksum transfer edge.
//  load_start in ACTIVE/SETTLE/FAIL: next cycle -> LOAD.
//    out_enable and done drop on that same edge.
//    key_out keeps its old value until a new CHECK passes.
//  load_start in LOAD: restart; idx=0; partial shadow discarded; no transfer is accepted on that edge.
//  load_start in CHECK: ignored (CHECK always completes).
//  kin_valid outside LOAD: ignored; kin_ready is 0 there.
//  kin_valid low in LOAD: stall indefinitely, no timeout.
//  rst at any point, including mid-LOAD or SETTLE: returns to reset values on the next edge.
//  key_out is only ever written in CHECK or by rst; it never shows a partial key.
// CONFIGURATION
//  RLL_KEY_LOCKOUT_EN defined:
//    2-bit+ fail_cnt; when CHECK fails with fail_cnt reaching MAX_FAIL -> LOCKOUT.
//    LOCKOUT: locked_out=1, key_out=0, out_enable=0, load_start ignored; only rst exits.
//    A passing CHECK clears fail_cnt.
//  Not defined: no fail_cnt, no LOCKOUT state; locked_out tied 0; FAIL always -> IDLE.
// TESTING
//  1. Load key 0x1234: chunks 4,3,2,1 then chk 4.
//     -> key_out=0x1234; out_enable=1 exactly 4 edges after the chk transfer (SETTLE_CYCLES=2); err=0.
//  2. Chunks 4,3,2,1 with chk 5 -> err=1, key_out=0, out_enable=0, FAIL then IDLE; err clears on next load_start.
//  3. After a passing load of 0x1234, reload 0xA5C3 (chunks 3,C,5,A, chk 0).
//     -> out_enable drops on the load_start edge; key_out stays 0x1234 until CHECK, then 0xA5C3.
//  4. load_start after 2 chunks, then full 0xBEEF sequence (chunks F,E,E,B, chk 4)
//     -> key_out=0xBEEF; earlier chunks discarded.
//  5. rst asserted mid-SETTLE and mid-LOAD -> all outputs at reset values next cycle; kin_ready=0.
//  6. (RLL_KEY_LOCKOUT_EN) three bad-checksum loads -> locked_out=1; 4th correct load ignored; rst clears.

Source files
------------

// File: rtl/rll_key_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rll_key_sequencer_if
//  Purpose  : Key-source handshake and locked-block control bundle.
//  Revision : 1.0
// ============================================================================
interface rll_key_sequencer_if #(
   parameter int KEY_WIDTH = 16,
   parameter int CHUNK_W   = 4
);
   logic                 load_start;
   logic                 kin_valid;
   logic [CHUNK_W-1:0]   kin_data;
   logic                 kin_ready;
   logic [KEY_WIDTH-1:0] key_out;
   logic                 out_enable;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic                 locked_out;

   modport master (
      output load_start, kin_valid, kin_data,
      input  kin_ready, key_out, out_enable, busy, done, err, locked_out
   );

   modport slave (
      input  load_start, kin_valid, kin_data,
      output kin_ready, key_out, out_enable, busy, done, err, locked_out
   );
endinterface
`default_nettype wire

// File: rtl/rll_key_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rll_key_sequencer
//  Purpose  : Loads a chunked logic-locking key, verifies its XOR-fold checksum
//             and gates the locked block's outputs. Optional: RLL_KEY_LOCKOUT_EN.
//  Revision : 1.0
// ============================================================================
module rll_key_sequencer #(
   parameter int KEY_WIDTH     = 16,
   parameter int CHUNK_W       = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_FAIL      = 3
) (
   input  wire logic          clk,
   input  wire logic          rst,
   rll_key_sequencer_if.slave bus
);
   localparam int NCHUNK = KEY_WIDTH / CHUNK_W;
   localparam int IDX_W  = $clog2(NCHUNK + 1);
   localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

   if (((KEY_WIDTH % CHUNK_W) != 0) || (SETTLE_CYCLES < 1) || (MAX_FAIL < 1)) begin : g_bad_params
      $error("rll_key_sequencer: illegal parameter combination");
   end

`ifdef RLL_KEY_LOCKOUT_EN
   localparam int FCW = ($clog2(MAX_FAIL + 1) < 2) ? 2 : $clog2(MAX_FAIL + 1);
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CHECK   = 3'd2,
      S_SETTLE  = 3'd3,
      S_ACTIVE  = 3'd4,
      S_FAIL    = 3'd5,
      S_LOCKOUT = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CHECK  = 3'd2,
      S_SETTLE = 3'd3,
      S_ACTIVE = 3'd4,
      S_FAIL   = 3'd5
   } state_t;
`endif

   state_t               r_state;
   logic [KEY_WIDTH-1:0] r_shadow;
   logic [CHUNK_W-1:0]   r_chk;
   logic [IDX_W-1:0]     r_idx;
   logic [SET_W-1:0]     r_settle_cnt;
   logic [KEY_WIDTH-1:0] r_key_out;
   logic                 r_out_enable;
   logic                 r_kin_ready;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;
   logic [CHUNK_W-1:0]   w_fold;
   logic                 w_start;
`ifdef RLL_KEY_LOCKOUT_EN
   logic [FCW-1:0]       r_fail_cnt;
   logic                 r_locked_out;
`endif

   always_comb begin
      w_fold = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         w_fold = w_fold ^ r_shadow[i*CHUNK_W +: CHUNK_W];
      end
   end

   // CHECK always completes; LOCKOUT only leaves through rst.
`ifdef RLL_KEY_LOCKOUT_EN
   assign w_start = bus.load_start && (r_state != S_CHECK) && (r_state != S_LOCKOUT);
`else
   assign w_start = bus.load_start && (r_state != S_CHECK);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_shadow     <= '0;
         r_chk        <= '0;
         r_idx        <= '0;
         r_settle_cnt <= '0;
         r_key_out    <= '0;
         r_out_enable <= 1'b0;
         r_kin_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
`ifdef RLL_KEY_LOCKOUT_EN
         r_fail_cnt   <= '0;
         r_locked_out <= 1'b0;
`endif
      end else if (w_start) begin
         // A start (or restart) discards any partial key; key_out stays put.
         r_state      <= S_LOAD;
         r_shadow     <= '0;
         r_idx        <= '0;
         r_err        <= 1'b0;
         r_kin_ready  <= 1'b1;
         r_busy       <= 1'b1;
         r_out_enable <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (bus.kin_valid) begin
                  if (r_idx == IDX_W'(NCHUNK)) begin
                     r_chk       <= bus.kin_data;
                     r_kin_ready <= 1'b0;
                     r_state     <= S_CHECK;
                  end else begin
                     // Shifting in from the top leaves the first chunk in the LSBs.
                     r_shadow <= {bus.kin_data, r_shadow[KEY_WIDTH-1:CHUNK_W]};
                     r_idx    <= r_idx + 1'b1;
                  end
               end
            end
            S_CHECK: begin
               if (w_fold == r_chk) begin
                  r_key_out    <= r_shadow;
                  r_settle_cnt <= '0;
                  r_state      <= S_SETTLE;
`ifdef RLL_KEY_LOCKOUT_EN
                  r_fail_cnt   <= '0;
`endif
               end else begin
                  r_key_out <= '0;
                  r_err     <= 1'b1;
                  r_busy    <= 1'b0;
`ifdef RLL_KEY_LOCKOUT_EN
                  r_fail_cnt <= r_fail_cnt + 1'b1;
                  if (r_fail_cnt >= FCW'(MAX_FAIL - 1)) begin
                     r_locked_out <= 1'b1;
                     r_state      <= S_LOCKOUT;
                  end else begin
                     r_state <= S_FAIL;
                  end
`else
                  r_state   <= S_FAIL;
`endif
               end
            end
            S_SETTLE: begin
               if (r_settle_cnt == SET_W'(SETTLE_CYCLES)) begin
                  r_out_enable <= 1'b1;
                  r_done       <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_ACTIVE;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end
            S_FAIL: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   assign bus.kin_ready  = r_kin_ready;
   assign bus.key_out    = r_key_out;
   assign bus.out_enable = r_out_enable;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
`ifdef RLL_KEY_LOCKOUT_EN
   assign bus.locked_out = r_locked_out;
`else
   assign bus.locked_out = 1'b0;
`endif

endmodule
`default_nettype wire
